// File: rtl/exec_ctrl.sv
// Sequencing controller for a 4-register, 8-bit datapath around an external combinational ALU.
// Latency: accept at edge N, operands registered N+1, result captured N+2, writeback pulse and register write at N+3.
// Backpressure: instr_ready is high only while idle, so one instruction is accepted every 4 cycles at most.
module exec_ctrl #(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_result,
    output logic        wb_valid,
    output logic [1:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        div_zero,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;
    logic [15:0] r_instr;
    logic [7:0]  r_rf [0:3];
    logic [7:0]  r_res;
    logic        r_dz;

    logic        w_accept;
    logic        w_ld_ops;
    logic        w_cap;
    logic        w_wb;
    logic [2:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [1:0]  w_rt;
    logic        w_imm_sel;
    logic [5:0]  w_imm6;
    logic [7:0]  w_rs_val;
    logic [7:0]  w_rt_val;
    logic        w_div0;
    logic        w_wr_en;

    // Field decode of the latched instruction.
    assign w_op      = r_instr[15:13];
    assign w_rd      = r_instr[12:11];
    assign w_rs      = r_instr[10:9];
    assign w_rt      = r_instr[8:7];
    assign w_imm_sel = r_instr[6];
    assign w_imm6    = r_instr[5:0];

    // R0 is hardwired to zero on every read port when R0_ZERO is set.
    assign w_rs_val = (R0_ZERO && (w_rs == 2'd0)) ? 8'h00 : r_rf[w_rs];
    assign w_rt_val = (R0_ZERO && (w_rt == 2'd0)) ? 8'h00 : r_rf[w_rt];
    assign dbg_data = (R0_ZERO && (dbg_addr == 2'd0)) ? 8'h00 : r_rf[dbg_addr];

    assign w_accept = instr_valid & instr_ready;
    assign w_div0   = (alu_op == 3'b011) && (alu_b == 8'h00);
    assign w_wr_en  = w_wb && !(R0_ZERO && (w_rd == 2'd0));

    // Out-of-reset flag: holds instr_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_live <= 1'b0;
        else     r_live <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: wait for acceptance in IDLE, then walk READ/EXEC/WB one per clock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: per-state strobes for the datapath.
    always_comb begin
        instr_ready = 1'b0;
        w_ld_ops    = 1'b0;
        w_cap       = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            S_IDLE:  instr_ready = r_live;
            S_READ:  w_ld_ops    = 1'b1;
            S_EXEC:  w_cap       = 1'b1;
            S_WB:    w_wb        = 1'b1;
            default: instr_ready = 1'b0;
        endcase
    end

    // Latch the instruction on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_instr <= 16'h0000;
        else if (w_accept) r_instr <= instr;
    end

    // Operand registers: loaded leaving READ and held through EXEC for the external ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
            alu_op <= 3'b111;
        end else if (w_ld_ops) begin
            alu_a  <= w_rs_val;
            alu_b  <= w_imm_sel ? {2'b00, w_imm6} : w_rt_val;
            alu_op <= w_op;
        end
    end

    // Result capture leaving EXEC; a divide by zero overrides the ALU with all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= 8'h00;
            r_dz  <= 1'b0;
        end else if (w_cap) begin
            r_res <= w_div0 ? 8'hFF : alu_result;
            r_dz  <= w_div0;
        end
    end

    // Writeback outputs: registered on the same edge as the register-file write, so the pulse and the new dbg_data appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= 2'd0;
            wb_data  <= 8'h00;
            div_zero <= 1'b0;
        end else if (w_wb) begin
            wb_valid <= 1'b1;
            wb_addr  <= w_rd;
            wb_data  <= r_res;
            div_zero <= r_dz;
        end else begin
            wb_valid <= 1'b0;
            div_zero <= 1'b0;
        end
    end

    // Register file write; lands before the next instruction can reach READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_rf[i] <= 8'h00;
        end else if (w_wr_en) begin
            r_rf[w_rd] <= r_res;
        end
    end

endmodule
